edge_pulse_counter: RTL and testbench

- Synchronous consumer of the asynchronous edge-pulse stream from the inverter/XOR edge-pulse generator; one pulse per input transition.
- Synchronises the pulse, rejects glitches shorter than MIN_WIDTH clocks, emits one evt strobe per qualified pulse and counts events.
- Raises a sticky irq when the count reaches a programmable threshold; software/upstream control acknowledges via irq_ack.

---
 rtl/edge_pulse_counter_pkg.sv | 12 +
 rtl/edge_pulse_counter_pulse_sync.sv | 28 ++
 rtl/edge_pulse_counter.sv | 144 ++++++++++++++
 tb/tb_edge_pulse_counter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_pulse_counter_pkg.sv
// Shared types for the edge-pulse counter: qualification FSM state encoding.
package edge_pulse_counter_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = 2'd0,
      ST_QUAL = 2'd1,
      ST_HELD = 2'd2
   } state_t;

endpackage

// File: rtl/edge_pulse_counter_pulse_sync.sv
// Multi-flop synchroniser bringing the asynchronous edge pulse into the clk domain.
module edge_pulse_counter_pulse_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], d};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/edge_pulse_counter.sv
// Qualifies synchronised edge pulses by minimum width, strobes evt per accepted
// pulse, counts events and raises sticky irq/overflow flags.
module edge_pulse_counter
   import edge_pulse_counter_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int MIN_WIDTH   = 2,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pulse_in,
   input  logic             enable,
   input  logic             clr,
   input  logic [CNT_W-1:0] threshold,
   input  logic             irq_ack,
   output logic             evt,
   output logic [CNT_W-1:0] count,
   output logic             irq,
   output logic             overflow
);

   localparam int HCNT_W = $clog2(MIN_WIDTH + 1);
   localparam logic [HCNT_W-1:0] MIN_W_L = HCNT_W'(MIN_WIDTH);

   logic              pulse_s;
   state_t            state_q, state_d;
   logic [HCNT_W-1:0] hcnt_q, hcnt_d, hcnt_inc;
   logic              accept;
   logic              evt_q, evt_d;
   logic [CNT_W-1:0]  count_q, count_d, count_inc;
   logic              irq_q, irq_d;
   logic              ovf_q, ovf_d;

   edge_pulse_counter_pulse_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_pulse_sync (
      .clk (clk),
      .rst (rst),
      .d   (pulse_in),
      .q   (pulse_s)
   );

   assign hcnt_inc = hcnt_q + 1'b1;

   // Qualification FSM: one accept per synchronised high period of MIN_WIDTH cycles.
   always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q;
      accept  = 1'b0;
      if (!enable) begin
         state_d = ST_IDLE;
         hcnt_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pulse_s) begin
                  hcnt_d = HCNT_W'(1);
                  if (MIN_WIDTH == 1) begin
                     state_d = ST_HELD;
                     accept  = 1'b1;
                  end else begin
                     state_d = ST_QUAL;
                  end
               end
            end
            ST_QUAL: begin
               if (!pulse_s) begin
                  state_d = ST_IDLE;
                  hcnt_d  = '0;
               end else begin
                  hcnt_d = hcnt_inc;
                  if (hcnt_inc == MIN_W_L) begin
                     state_d = ST_HELD;
                     accept  = 1'b1;
                  end
               end
            end
            ST_HELD: begin
               if (!pulse_s) begin
                  state_d = ST_IDLE;
                  hcnt_d  = '0;
               end
            end
            default: begin
               state_d = ST_IDLE;
               hcnt_d  = '0;
            end
         endcase
      end
   end

   assign count_inc = count_q + 1'b1;

   // clr beats accept and irq set; irq set beats irq_ack.
   always_comb begin
      evt_d   = accept;
      count_d = count_q;
      irq_d   = irq_q;
      ovf_d   = ovf_q;
      if (clr) begin
         count_d = '0;
         irq_d   = 1'b0;
         ovf_d   = 1'b0;
      end else begin
         if (irq_ack) begin
            irq_d = 1'b0;
         end
         if (accept) begin
            count_d = count_inc;
            if (count_inc == '0) begin
               ovf_d = 1'b1;
            end
            if ((threshold != '0) && (count_inc == threshold)) begin
               irq_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         hcnt_q  <= '0;
         evt_q   <= 1'b0;
         count_q <= '0;
         irq_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hcnt_q  <= hcnt_d;
         evt_q   <= evt_d;
         count_q <= count_d;
         irq_q   <= irq_d;
         ovf_q   <= ovf_d;
      end
   end

   assign evt      = evt_q;
   assign count    = count_q;
   assign irq      = irq_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_edge_pulse_counter.sv
// Bench for edge_pulse_counter: width-qualification table, latency, irq,
// wrap, clr, enable and async-reset corner sequences.
module tb_edge_pulse_counter;

   localparam int CNT_W = 8;

   logic             clk;
   logic             rst;
   logic             pulse_in;
   logic             enable;
   logic             clr;
   logic [CNT_W-1:0] threshold;
   logic             irq_ack;
   logic             evt;
   logic [CNT_W-1:0] count;
   logic             irq;
   logic             overflow;

   int checks   = 0;
   int failures = 0;
   int evt_seen = 0;

   logic [CNT_W-1:0] exp_q[$];
   logic [CNT_W-1:0] exp_count;

   typedef struct {
      int hi;
      bit acc;
   } vec_t;

   vec_t vecs[8];

   edge_pulse_counter #(
      .SYNC_STAGES(2),
      .MIN_WIDTH  (2),
      .CNT_W      (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .pulse_in  (pulse_in),
      .enable    (enable),
      .clr       (clr),
      .threshold (threshold),
      .irq_ack   (irq_ack),
      .evt       (evt),
      .count     (count),
      .irq       (irq),
      .overflow  (overflow)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // scoreboard: every evt pops the count value it must carry
   always @(negedge clk) begin
      if (!rst && evt) begin
         evt_seen++;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected_evt: got evt with count %0d expected no evt at %0t", count, $time);
         end else begin
            check("sb_evt_count", 32'(count), 32'(exp_q.pop_front()));
         end
      end
   end

   // drivers
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_accept();
      exp_count = exp_count + 1'b1;
      exp_q.push_back(exp_count);
   endtask

   task automatic pulse(input int hi, input int lo);
      pulse_in = 1'b1;
      repeat (hi) step();
      pulse_in = 1'b0;
      repeat (lo) step();
   endtask

   initial begin
      int evt_before;
      rst       = 1'b1;
      pulse_in  = 1'b0;
      enable    = 1'b1;
      clr       = 1'b0;
      threshold = '0;
      irq_ack   = 1'b0;
      exp_count = '0;

      vecs[0] = '{hi: 1, acc: 1'b0};
      vecs[1] = '{hi: 2, acc: 1'b1};
      vecs[2] = '{hi: 3, acc: 1'b1};
      vecs[3] = '{hi: 1, acc: 1'b0};
      vecs[4] = '{hi: 6, acc: 1'b1};
      vecs[5] = '{hi: 2, acc: 1'b1};
      vecs[6] = '{hi: 1, acc: 1'b0};
      vecs[7] = '{hi: 4, acc: 1'b1};

      repeat (3) step();
      rst = 1'b0;
      check("rst_evt", 32'(evt), 0);
      check("rst_count", 32'(count), 0);
      check("rst_irq", 32'(irq), 0);
      check("rst_overflow", 32'(overflow), 0);
      step();

      // latency: evt exactly on edge 4 after the first high sample
      expect_accept();
      pulse_in = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         step();
         if (e == 4) pulse_in = 1'b0;
         check($sformatf("lat_evt_edge%0d", e), 32'(evt), (e == 4) ? 1 : 0);
      end
      repeat (4) step();
      check("lat_count", 32'(count), 1);

      // width qualification table
      for (int i = 0; i < 8; i++) begin
         evt_before = evt_seen;
         if (vecs[i].acc) expect_accept();
         pulse(vecs[i].hi, 8);
         check($sformatf("vec%0d_evts", i), 32'(evt_seen - evt_before), vecs[i].acc ? 1 : 0);
         check($sformatf("vec%0d_count", i), 32'(count), 32'(exp_count));
      end

      // threshold irq and ack
      clr = 1'b1;
      step();
      clr = 1'b0;
      exp_count = '0;
      check("clr_count", 32'(count), 0);
      threshold = 8'd3;
      for (int i = 1; i <= 3; i++) begin
         expect_accept();
         pulse(4, 10);
         check($sformatf("thr_count%0d", i), 32'(count), 32'(i));
         check($sformatf("thr_irq%0d", i), 32'(irq), (i == 3) ? 1 : 0);
      end
      irq_ack = 1'b1;
      step();
      irq_ack = 1'b0;
      check("ack_irq", 32'(irq), 0);
      threshold = 8'd4;
      expect_accept();
      pulse_in = 1'b1;
      repeat (3) step();
      irq_ack = 1'b1;
      step();
      irq_ack = 1'b0;
      pulse_in = 1'b0;
      check("setack_evt", 32'(evt), 1);
      check("setack_irq", 32'(irq), 1);
      repeat (10) step();
      check("setack_count", 32'(count), 4);

      // wrap and overflow
      threshold = '0;
      clr = 1'b1;
      step();
      clr = 1'b0;
      exp_count = '0;
      check("clr2_irq", 32'(irq), 0);
      for (int i = 1; i <= 256; i++) begin
         expect_accept();
         pulse(2, 5);
         if (i == 255) begin
            check("wrap_pre_count", 32'(count), 255);
            check("wrap_pre_ovf", 32'(overflow), 0);
         end
      end
      check("wrap_count", 32'(count), 0);
      check("wrap_ovf", 32'(overflow), 1);
      check("wrap_irq", 32'(irq), 0);
      clr = 1'b1;
      step();
      clr = 1'b0;
      check("clr3_ovf", 32'(overflow), 0);
      check("clr3_count", 32'(count), 0);

      // clr on the accept edge, with a threshold the increment would hit
      threshold = 8'd1;
      exp_q.push_back(8'd0);
      exp_count = '0;
      pulse_in = 1'b1;
      repeat (3) step();
      clr = 1'b1;
      step();
      clr = 1'b0;
      pulse_in = 1'b0;
      check("clracc_evt", 32'(evt), 1);
      check("clracc_count", 32'(count), 0);
      check("clracc_irq", 32'(irq), 0);
      check("clracc_ovf", 32'(overflow), 0);
      repeat (8) step();

      // enable low through a whole pulse: nothing counted
      threshold = '0;
      evt_before = evt_seen;
      pulse_in = 1'b1;
      step();
      enable = 1'b0;
      repeat (6) step();
      pulse_in = 1'b0;
      repeat (6) step();
      enable = 1'b1;
      check("dis_evts", 32'(evt_seen - evt_before), 0);
      check("dis_count", 32'(count), 0);

      // re-enable mid-pulse: requalifies from IDLE
      pulse_in = 1'b1;
      enable = 1'b0;
      repeat (5) step();
      expect_accept();
      enable = 1'b1;
      step();
      check("reen_evt_e1", 32'(evt), 0);
      step();
      check("reen_evt_e2", 32'(evt), 1);
      pulse_in = 1'b0;
      repeat (8) step();
      check("reen_count", 32'(count), 1);

      // get irq set so the async reset has something to clear
      threshold = 8'd2;
      expect_accept();
      pulse(4, 10);
      check("pre_rst_irq", 32'(irq), 1);

      // async reset mid-QUAL, released with pulse_in still high
      pulse_in = 1'b1;
      repeat (3) step();
      #2;
      rst = 1'b1;
      #1;
      check("arst_count", 32'(count), 0);
      check("arst_irq", 32'(irq), 0);
      check("arst_evt", 32'(evt), 0);
      exp_count = '0;
      threshold = '0;
      step();
      rst = 1'b0;
      expect_accept();
      for (int e = 1; e <= 5; e++) begin
         step();
         check($sformatf("postrst_evt_edge%0d", e), 32'(evt), (e == 4) ? 1 : 0);
      end
      pulse_in = 1'b0;
      repeat (6) step();
      check("postrst_count", 32'(count), 1);

      check("sb_drained", 32'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
